// File: rtl/aes_job_master.sv
// rtl/aes_job_master.sv - AXI master that programs the AES slave for one 128-bit job at a time
// Optional: define AES_MASTER_TIMEOUT_EN to bound each STATUS poll phase to POLL_LIMIT reads.
module aes_job_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ID_BITS    = 4,
    parameter int                    MST_ID     = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    POLL_LIMIT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [127:0]          job_key,
    input  logic [127:0]          job_block,
    input  logic                  job_encdec,
    input  logic                  job_rekey,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [127:0]          res_data,
    output logic                  res_err,
    output logic                  busy_o,
    output logic [ID_BITS-1:0]    awid,
    output logic [ADDR_WIDTH-1:0] awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    output logic                  wlast,
    input  logic                  wready,
    input  logic [ID_BITS-1:0]    bid,
    input  logic [2:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,
    output logic [ID_BITS-1:0]    arid,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic [7:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_BITS-1:0]    rid,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [2:0]            rresp,
    input  logic                  rvalid,
    input  logic                  rlast,
    output logic                  rready
);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_KEY, S_WR_CFG, S_WR_INIT, S_POLL_RDY,
        S_WR_BLK, S_WR_NEXT, S_POLL_VLD, S_RD_RES, S_RESP
    } state_t;

    state_t         state, state_d;
    logic [1:0]     idx;
    logic           aw_done, w_done, ar_done;
    logic [127:0]   key_q, blk_q;
    logic           encdec_q, rekey_q, key_valid;
    logic           wr_state, rd_state, poll_state;
    logic           wr_cpl, rd_cpl, bus_err, poll_hit, poll_expire, last_word;
    logic           unused_ok;

    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[127:96];
            2'd1:    return v[95:64];
            2'd2:    return v[63:32];
            default: return v[31:0];
        endcase
    endfunction

    assign awid    = ID_BITS'(MST_ID);
    assign arid    = ID_BITS'(MST_ID);
    assign awlen   = 8'd0;
    assign arlen   = 8'd0;
    assign awsize  = 3'b010;
    assign arsize  = 3'b010;
    assign awburst = 2'b01;
    assign arburst = 2'b01;
    assign wstrb   = 4'hF;
    assign wlast   = 1'b1;
    assign unused_ok = ^{bid, rid, rlast, rdata[DATA_WIDTH-1:2]};

    assign wr_state   = state inside {S_WR_KEY, S_WR_CFG, S_WR_INIT, S_WR_BLK, S_WR_NEXT};
    assign poll_state = state inside {S_POLL_RDY, S_POLL_VLD};
    assign rd_state   = poll_state || (state == S_RD_RES);

    // AW and W are tracked separately so either may be accepted first
    assign awvalid = wr_state && !aw_done;
    assign wvalid  = wr_state && !w_done;
    assign bready  = wr_state && aw_done && w_done;
    assign arvalid = rd_state && !ar_done;
    assign rready  = rd_state && ar_done;

    assign wr_cpl    = bvalid && bready;
    assign rd_cpl    = rvalid && rready;
    assign bus_err   = (wr_cpl && bresp != 3'b000) || (rd_cpl && rresp != 3'b000);
    assign poll_hit  = (state == S_POLL_RDY) ? rdata[0] : rdata[1];
    assign last_word = (idx == 2'd3);

    assign job_ready = (state == S_IDLE);
    assign res_valid = (state == S_RESP);
    assign busy_o    = (state != S_IDLE);

    always_comb begin
        awaddr = BASE_ADDR;
        wdata  = '0;
        case (state)
            S_WR_KEY:  begin
                awaddr = BASE_ADDR + ADDR_WIDTH'({4'h4, idx, 2'b00});
                wdata  = word_of(key_q, idx);
            end
            S_WR_CFG:  begin
                awaddr = BASE_ADDR + ADDR_WIDTH'(8'h28);
                wdata  = {{(DATA_WIDTH-1){1'b0}}, encdec_q};
            end
            S_WR_INIT: begin
                awaddr = BASE_ADDR + ADDR_WIDTH'(8'h20);
                wdata  = DATA_WIDTH'(1);
            end
            S_WR_BLK:  begin
                awaddr = BASE_ADDR + ADDR_WIDTH'({4'h8, idx, 2'b00});
                wdata  = word_of(blk_q, idx);
            end
            S_WR_NEXT: begin
                awaddr = BASE_ADDR + ADDR_WIDTH'(8'h20);
                wdata  = DATA_WIDTH'(2);
            end
            default: ;
        endcase
    end

    assign araddr = BASE_ADDR + ((state == S_RD_RES) ? ADDR_WIDTH'({4'hC, idx, 2'b00})
                                                     : ADDR_WIDTH'(8'h24));

`ifdef AES_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(POLL_LIMIT + 1);
    logic [CNT_W-1:0] poll_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                   poll_cnt <= '0;
        else if (state_d != state)     poll_cnt <= '0;
        else if (poll_state && rd_cpl) poll_cnt <= poll_cnt + CNT_W'(1);
    end

    assign poll_expire = poll_state && rd_cpl && !poll_hit &&
                         (poll_cnt == CNT_W'(POLL_LIMIT - 1));
`else
    assign poll_expire = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= S_IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:     if (job_valid)
                            state_d = job_rekey ? S_WR_KEY : (key_valid ? S_WR_CFG : S_RESP);
            S_WR_KEY:   if (wr_cpl && last_word) state_d = S_WR_CFG;
            S_WR_CFG:   if (wr_cpl) state_d = rekey_q ? S_WR_INIT : S_WR_BLK;
            S_WR_INIT:  if (wr_cpl) state_d = S_POLL_RDY;
            S_POLL_RDY: if (rd_cpl && poll_hit) state_d = S_WR_BLK;
            S_WR_BLK:   if (wr_cpl && last_word) state_d = S_WR_NEXT;
            S_WR_NEXT:  if (wr_cpl) state_d = S_POLL_VLD;
            S_POLL_VLD: if (rd_cpl && poll_hit) state_d = S_RD_RES;
            S_RD_RES:   if (rd_cpl && last_word) state_d = S_RESP;
            S_RESP:     if (res_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (bus_err || poll_expire) state_d = S_RESP;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx       <= 2'd0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            ar_done   <= 1'b0;
            key_q     <= '0;
            blk_q     <= '0;
            encdec_q  <= 1'b0;
            rekey_q   <= 1'b0;
            key_valid <= 1'b0;
            res_data  <= '0;
            res_err   <= 1'b0;
        end else begin
            if (awvalid && awready) aw_done <= 1'b1;
            if (wvalid && wready)   w_done  <= 1'b1;
            if (wr_cpl) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (arvalid && arready) ar_done <= 1'b1;
            if (rd_cpl)             ar_done <= 1'b0;

            if (state_d != state)       idx <= 2'd0;
            else if (wr_cpl || rd_cpl)  idx <= idx + 2'd1;

            if (job_valid && job_ready) begin
                key_q    <= job_key;
                blk_q    <= job_block;
                encdec_q <= job_encdec;
                rekey_q  <= job_rekey;
                res_err  <= !job_rekey && !key_valid;
                if (job_rekey) key_valid <= 1'b0;
            end
            if (state == S_POLL_RDY && rd_cpl && poll_hit && !bus_err) key_valid <= 1'b1;
            // Words arrive MSW first, so shifting left lands word i at [127-32i -: 32]
            if (state == S_RD_RES && rd_cpl && !bus_err) res_data <= {res_data[95:0], rdata[31:0]};
            if (bus_err || poll_expire) begin
                res_err <= 1'b1;
                if (rekey_q) key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_aes_job_master.sv
// tb/tb_aes_job_master.sv - directed table-driven bench for aes_job_master with a small AES slave model
module tb_aes_job_master;

    localparam logic [127:0] K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         job_valid = 1'b0, job_ready, job_encdec = 1'b0, job_rekey = 1'b0;
    logic [127:0] job_key = '0, job_block = '0;
    logic         res_valid, res_ready = 1'b0, res_err, busy_o;
    logic [127:0] res_data;
    logic [3:0]   awid, arid;
    logic [31:0]  awaddr, araddr, wdata;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [1:0]   awburst, arburst;
    logic         awvalid, awready, wvalid, wlast, wready, bready, arvalid, arready, rready;
    logic [3:0]   wstrb;
    logic [2:0]   bresp = 3'b0, rresp = 3'b0;
    logic         bvalid = 1'b0, rvalid = 1'b0;
    logic [31:0]  rdata = '0;

    always #5 clk = ~clk;

    aes_job_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_BITS(4), .MST_ID(1),
                     .BASE_ADDR(32'h0), .POLL_LIMIT(4)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .job_valid(job_valid), .job_ready(job_ready), .job_key(job_key), .job_block(job_block),
        .job_encdec(job_encdec), .job_rekey(job_rekey),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
        .busy_o(busy_o),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
        .bid(4'd0), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(4'd0), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rlast(1'b1), .rready(rready)
    );

    // Slave model: registers the AES map and returns canned results for the known key/vectors
    int           aw_stall = 0;
    logic [31:0]  err_addr = 32'hFFFF_FFFF;
    logic         force_zero = 1'b0;
    int           aw_wait = 0, cyc = 0, vld_polls = 0;
    int           n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0, n_status = 0, n_vld_cyc = 0;
    int           aw_cyc [64];
    int           w_cyc  [64];
    logic         aw_got = 1'b0, w_got = 1'b0, ar_got = 1'b0, inited = 1'b0;
    logic [31:0]  aw_q = '0, w_q = '0, ar_q = '0, cfg_reg = '0;
    logic [127:0] key_reg = '0, blk_reg = '0, result = '0;

    assign awready = (aw_wait >= aw_stall);
    assign wready  = 1'b1;
    assign arready = 1'b1;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (awvalid || arvalid) n_vld_cyc <= n_vld_cyc + 1;
        if (awvalid && !awready) aw_wait <= aw_wait + 1;
        else                     aw_wait <= 0;
        if (!rst_ni) begin
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
        end else begin
            if (awvalid && awready) begin
                aw_q <= awaddr; aw_got <= 1'b1; aw_cyc[n_aw % 64] <= cyc; n_aw <= n_aw + 1;
            end
            if (wvalid && wready) begin
                w_q <= wdata; w_got <= 1'b1; w_cyc[n_w % 64] <= cyc; n_w <= n_w + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; n_b <= n_b + 1;
            end
            if (aw_got && w_got && !bvalid) begin
                aw_got <= 1'b0; w_got <= 1'b0; bvalid <= 1'b1; bresp <= 3'b0;
                if (aw_q[7:4] == 4'h4) key_reg[127 - 32*aw_q[3:2] -: 32] <= w_q;
                if (aw_q[7:4] == 4'h8) blk_reg[127 - 32*aw_q[3:2] -: 32] <= w_q;
                if (aw_q[7:0] == 8'h28) cfg_reg <= w_q;
                if (aw_q[7:0] == 8'h20 && w_q == 32'h1) inited <= 1'b1;
                if (aw_q[7:0] == 8'h20 && w_q == 32'h2) begin
                    vld_polls <= 2;
                    if (key_reg == K && cfg_reg[0] && blk_reg == P)       result <= C;
                    else if (key_reg == K && !cfg_reg[0] && blk_reg == C) result <= P;
                    else                                                  result <= {4{32'hBAD0BAD0}};
                end
            end
            if (arvalid && arready) begin
                ar_q <= araddr; ar_got <= 1'b1; n_ar <= n_ar + 1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; n_r <= n_r + 1;
            end
            if (ar_got && !rvalid) begin
                ar_got <= 1'b0; rvalid <= 1'b1;
                rresp  <= (ar_q == err_addr) ? 3'b010 : 3'b000;
                if (ar_q[7:0] == 8'h24) begin
                    rdata <= {30'b0, (vld_polls == 0) && !force_zero, inited && !force_zero};
                    if (vld_polls > 0) vld_polls <= vld_polls - 1;
                    n_status <= n_status + 1;
                end else begin
                    rdata <= result[127 - 32*ar_q[3:2] -: 32];
                end
            end
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_job(input logic rk, input logic ed, input logic [127:0] blk, input int hold,
                           output logic [127:0] d, output logic e, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        job_valid = 1'b1; job_rekey = rk; job_encdec = ed; job_key = K; job_block = blk;
        while (!job_ready && w < 50) begin @(negedge clk); w++; end
        @(negedge clk);
        job_valid = 1'b0;
        lat = 0;
        while (!res_valid && lat < 2000) begin @(negedge clk); lat++; end
        if (!res_valid) begin
            n_tests++; n_fail++;
            $display("FAIL job_timeout: res_valid=%0b after %0d cycles, required 1", res_valid, lat);
        end
        d = res_data;
        e = res_err;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            chk("resp_hold_valid", res_valid, 1);
            chk("resp_hold_data", res_data, d);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic         rekey;
        logic         encdec;
        logic [127:0] block;
        logic [127:0] exp_data;
        int           exp_wr;
        int           exp_rd;
    } vec_t;

    vec_t vecs [4];

    initial begin
        logic [127:0] d;
        logic         e;
        int           lat, b0, r0, aw0, w0, ar0, v0, s0;

        vecs[0] = '{1'b1, 1'b1, P, C, 11, 8};
        vecs[1] = '{1'b0, 1'b0, C, P, 6, 7};
        vecs[2] = '{1'b0, 1'b1, P, C, 6, 7};
        vecs[3] = '{1'b1, 1'b0, C, P, 11, 8};

        repeat (3) @(negedge clk);
        chk("rst_job_ready", job_ready, 1);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, res_err}, 0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("const_aw", {awid, awlen, awsize, awburst}, {4'd1, 8'd0, 3'b010, 2'b01});
        chk("const_ar", {arid, arlen, arsize, arburst}, {4'd1, 8'd0, 3'b010, 2'b01});
        chk("const_w", {wstrb, wlast}, {4'hF, 1'b1});

        // Reuse of a key that was never initialised
        v0 = n_vld_cyc; aw0 = n_aw; ar0 = n_ar;
        run_job(1'b0, 1'b1, P, 0, d, e, lat);
        chk("uninit_err", e, 1);
        chk("uninit_lat_lt3", lat < 3, 1);
        chk("uninit_no_valid", n_vld_cyc - v0, 0);
        chk("uninit_no_txn", (n_aw - aw0) + (n_ar - ar0), 0);

        for (int i = 0; i < 4; i++) begin
            b0 = n_b; r0 = n_r;
            run_job(vecs[i].rekey, vecs[i].encdec, vecs[i].block, 0, d, e, lat);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), e, 0);
            chk($sformatf("vec%0d_writes", i), n_b - b0, vecs[i].exp_wr);
            chk($sformatf("vec%0d_reads", i), n_r - r0, vecs[i].exp_rd);
            chk($sformatf("vec%0d_cfg", i), cfg_reg, {31'b0, vecs[i].encdec});
            chk($sformatf("vec%0d_busy_after", i), busy_o, 0);
        end

        // AW stalled three cycles while W goes straight through
        aw_stall = 3; aw0 = n_aw; w0 = n_w; b0 = n_b;
        run_job(1'b0, 1'b1, P, 0, d, e, lat);
        aw_stall = 0;
        chk("stall_data", d, C);
        chk("stall_err", e, 0);
        chk("stall_aw_count", n_aw - aw0, 6);
        chk("stall_w_count", n_w - w0, 6);
        chk("stall_b_count", n_b - b0, 6);
        chk("stall_w_lead", aw_cyc[aw0 % 64] - w_cyc[w0 % 64], 3);

        // Error response on RESULT word 1; response held to check stability and silence
        err_addr = 32'h0000_00C4; aw0 = n_aw; ar0 = n_ar;
        run_job(1'b0, 1'b1, P, 4, d, e, lat);
        err_addr = 32'hFFFF_FFFF;
        chk("rerr_err", e, 1);
        chk("rerr_ar_count", n_ar - ar0, 5);
        chk("rerr_aw_count", n_aw - aw0, 6);

`ifdef AES_MASTER_TIMEOUT_EN
        force_zero = 1'b1; s0 = n_status;
        run_job(1'b0, 1'b1, P, 0, d, e, lat);
        force_zero = 1'b0;
        chk("timeout_err", e, 1);
        chk("timeout_status_reads", n_status - s0, 4);
`endif

        // Asynchronous reset while polling for valid
        force_zero = 1'b1;
        @(negedge clk);
        job_valid = 1'b1; job_rekey = 1'b0; job_encdec = 1'b1; job_key = K; job_block = P;
        @(negedge clk);
        job_valid = 1'b0;
        lat = 0;
        while (!(arvalid && araddr == 32'h24) && lat < 200) begin @(negedge clk); lat++; end
        chk("reach_poll_vld", arvalid && araddr == 32'h24, 1);
        #1 rst_ni = 1'b0;
        #1;
        chk("arst_job_ready", job_ready, 1);
        chk("arst_busy", busy_o, 0);
        chk("arst_res", {res_valid, res_err}, 0);
        chk("arst_res_data", res_data, 0);
        chk("arst_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        force_zero = 1'b0;
        v0 = n_vld_cyc;
        run_job(1'b0, 1'b1, P, 0, d, e, lat);
        chk("post_rst_uninit_err", e, 1);
        chk("post_rst_no_valid", n_vld_cyc - v0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
        $fatal(1);
    end

endmodule
